pipelined_adder_tree: RTL and testbench
=======================================

Name: pipelined_adder_tree

Overview:
- Parametrised, pipelined successor to the team's fixed 4-input combinational adder tree.
- Sums NUM_IN unsigned lanes of WIDTH bits, with one register stage per tree level.
- Carries a valid/ready handshake with full backpressure.
- Used wherever wide multi-operand sums would otherwise break timing in the datapath.

Parameters:
- WIDTH, 8, bit width of each input lane.
- NUM_IN, 4, number of lanes; power of two, >= 2; elaboration error otherwise.
- LEVELS, $clog2(NUM_IN), derived (localparam): tree depth and pipeline latency.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds an operand set.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  NUM_IN*WIDTH  packed lanes; lane i = in_data[i*WIDTH +: WIDTH].
- out_valid  output  1  out_sum holds a result.
- out_ready  input  1  downstream consumes out_sum this cycle.
- out_sum  output  WIDTH+LEVELS  full-precision sum of all lanes; never overflows.

Behaviour:
- Reset: clock and reset port names are clk and rst. Reset is synchronous and active-high: sampled on the rising clk edge.
  - While rst is high at an edge, every stage valid bit clears to 0.
  - Every stage data register, including out_sum, clears to 0.
  - After reset: out_valid=0, out_sum=0, in_ready=1.
  - Reset mid-operation discards all in-flight results; nothing is emitted for them.
- Tree structure:
  - Level k (1..LEVELS) holds NUM_IN>>k partial sums, each WIDTH+k bits wide.
  - Partial sum j at level k = zero-extended sum of pair 2j and 2j+1 from level k-1.
  - Level 0 is in_data itself and is not registered.
  - Level LEVELS holds one value, which drives out_sum.
- Stall control:
  - Global advance signal adv = !out_valid || out_ready.
  - in_ready = adv. This is combinational from out_valid and out_ready, with no dependence on in_valid.
  - When adv=1, all levels shift one step. Stage-1 valid <= in_valid. Stage k valid <= stage k-1 valid.
  - When adv=0, every data and valid register holds its value.
  - Bubbles are not collapsed: one global stall.
- Latency and throughput:
  - A set accepted at edge T (in_valid && in_ready) appears with out_valid=1 after edge T+LEVELS-1. It is visible in the cycle following that edge, giving LEVELS cycles of latency.
  - Throughput is one result per cycle when out_ready is held high.
- Handshake rules:
  - Once out_valid=1, out_sum stays stable until out_ready=1.
  - Invalid stages may still update their data registers; contents are don't-care while invalid.
  - Simultaneous output and input on the same edge (out_valid && out_ready together with in_valid && in_ready): both handshakes complete and the pipeline shifts.
- Width boundary:
  - All lanes at 2^WIDTH-1 gives out_sum = NUM_IN*(2^WIDTH-1), exactly representable.
- NUM_IN=2 case: a single register level with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_TREE_SIGNED_EN
- Defined:
  - Lanes are two's-complement.
  - Each level sign-extends its operands by one bit before adding.
  - out_sum is the signed full-precision sum.
- Undefined:
  - Unsigned zero-extension as described above.
- Port list, widths, latency and handshake are identical in both builds.

Test Plan:
1. Reset then idle, NUM_IN=4, WIDTH=8: hold rst=1 for 2 cycles -> out_valid=0, out_sum=0, in_ready=1. No out_valid while in_valid=0.
2. Single transfer, lanes {1,2,3,4}, out_ready=1: out_sum=10 with out_valid=1 exactly 2 cycles after acceptance, then out_valid drops.
3. Max values, all lanes 255: out_sum=1020 (10'h3FC). For NUM_IN=8, all lanes 255 gives 2040 on 11 bits.
4. Backpressure: stream 5 sets with sums 10,20,30,40,50 while out_ready=0 from cycle 3 to 6.
   - in_ready=0 whenever out_valid && !out_ready.
   - out_sum is held stable during the stall.
   - All 5 sums arrive in order with no loss or duplication.
5. Reset mid-stream: rst asserted with 2 results in flight -> next cycle out_valid=0, out_sum=0. Those results are never emitted.
6. Signed build (macro defined), lanes {-1,-2,3,-128}: out_sum = -128 as a 10-bit value (10'h380). The unsigned build with the same bits gives 255+254+3+128 = 640.

Source files
------------

// File: rtl/pipelined_adder_tree.sv
// Pipelined multi-operand adder tree: NUM_IN lanes summed over $clog2(NUM_IN) registered levels
// under one global valid/ready stall. Define PIPELINED_ADDER_TREE_SIGNED_EN for two's-complement lanes.
module pipelined_adder_tree #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_IN*WIDTH-1:0]           in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH+$clog2(NUM_IN)-1:0]   out_sum
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int OUT_W  = WIDTH + LEVELS;

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
    $error("pipelined_adder_tree: NUM_IN must be a power of two and at least 2");
  end

  logic              adv;
  logic [LEVELS:1]   vld_q;

  // Every tree node, extended to OUT_W, so each level can slice its exact operand width.
  logic [OUT_W-1:0]  node [0:LEVELS][0:NUM_IN-1];

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LEVELS];
  assign out_sum   = node[LEVELS][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[1] <= in_valid;
      for (int k = 2; k <= LEVELS; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
`ifdef PIPELINED_ADDER_TREE_SIGNED_EN
    assign node[0][i] = OUT_W'($signed(in_data[i*WIDTH +: WIDTH]));
`else
    assign node[0][i] = OUT_W'(in_data[i*WIDTH +: WIDTH]);
`endif
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int W = WIDTH + k;
    localparam int N = NUM_IN >> k;

    for (genvar j = 0; j < NUM_IN; j++) begin : g_node
      if (j < N) begin : g_add
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum_q;

        // Operands arrive pre-extended by one bit (zero or sign) from the previous level's view.
        assign a = node[k-1][2*j][W-1:0];
        assign b = node[k-1][2*j+1][W-1:0];

        always_ff @(posedge clk) begin
          if (rst) begin
            sum_q <= '0;
          end else if (adv) begin
            sum_q <= a + b;
          end
        end

`ifdef PIPELINED_ADDER_TREE_SIGNED_EN
        assign node[k][j] = OUT_W'($signed(sum_q));
`else
        assign node[k][j] = OUT_W'(sum_q);
`endif
      end else begin : g_unused
        assign node[k][j] = '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: a driver pushes model sums on acceptance, a monitor
// pops and compares on every output handshake. Honours PIPELINED_ADDER_TREE_SIGNED_EN in the model.
module tb_pipelined_adder_tree;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int OUT_W  = WIDTH + LEVELS;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_sum;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];
  logic        stall_pend = 1'b0;
  logic [31:0] held_sum = '0;

  pipelined_adder_tree #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: plain integer sum of the lanes, reduced to the output width.
  function automatic logic [31:0] modelSum(input logic [NUM_IN*WIDTH-1:0] d);
    int s;
    logic [WIDTH-1:0] lane;
    logic [OUT_W-1:0] r;
    s = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      lane = d[i*WIDTH +: WIDTH];
`ifdef PIPELINED_ADDER_TREE_SIGNED_EN
      s = s + int'($signed(lane));
`else
      s = s + int'(lane);
`endif
    end
    r = s[OUT_W-1:0];
    return 32'(r);
  endfunction

  function automatic logic [NUM_IN*WIDTH-1:0] packLanes(input int l0, input int l1,
                                                        input int l2, input int l3);
    logic [NUM_IN*WIDTH-1:0] d;
    d = '0;
    d[0*WIDTH +: WIDTH] = l0[WIDTH-1:0];
    d[1*WIDTH +: WIDTH] = l1[WIDTH-1:0];
    d[2*WIDTH +: WIDTH] = l2[WIDTH-1:0];
    d[3*WIDTH +: WIDTH] = l3[WIDTH-1:0];
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, required, required, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the set.
  task automatic applyStimulus(input logic [NUM_IN*WIDTH-1:0] d);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(modelSum(d));
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  // Latency check for an isolated set with out_ready held high.
  task automatic directedCheck(input string name, input logic [NUM_IN*WIDTH-1:0] d);
    logic [31:0] e;
    e = modelSum(d);
    applyStimulus(d);
    for (int c = 1; c < LEVELS; c++) begin
      @(negedge clk);
      checkOutput({name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_sum"}, 32'(out_sum), e);
    @(negedge clk);
    checkOutput({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake rule, stall stability and in-order scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_pend <= 1'b0;
    end else begin
      checkOutput("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_pend) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_sum", 32'(out_sum), held_sum);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL spurious_out: got sum %0d, expected no output", out_sum);
        end else begin
          checkOutput("scoreboard_sum", 32'(out_sum), exp_q.pop_front());
        end
      end
      stall_pend <= out_valid && !out_ready;
      held_sum   <= 32'(out_sum);
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Directed sums with latency checks
    directedCheck("lanes_1234", packLanes(1, 2, 3, 4));
    directedCheck("lanes_max", packLanes(255, 255, 255, 255));
    directedCheck("lanes_mixed", packLanes(-1, -2, 3, -128));
    directedCheck("lanes_zero", packLanes(0, 0, 0, 0));

    // Backpressure: five sets summing to 10..50, out_ready low for four cycles
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          applyStimulus(packLanes(k, 2*k, 3*k, 4*k));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (LEVELS + 3) @(posedge clk);
    #1;
    checkOutput("backpressure_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two results in flight
    out_ready = 1'b0;
    applyStimulus(packLanes(5, 6, 7, 8));
    applyStimulus(packLanes(9, 10, 11, 12));
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("midreset_no_emit", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [NUM_IN*WIDTH-1:0] d;
          for (int i = 0; i < NUM_IN; i++) begin
            d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
          applyStimulus(d);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int c = 0; c < 150; c++) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;

    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
